// File: rtl/mul_result_drain.sv
// Result collector for the six-lane bf16 multiplier chain: packs strobed lanes
// into a FIFO and drains them one per cycle on a valid/ready stream.
module mul_result_drain #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [191:0]             chain_z,
    input  logic [5:0]               chain_stbs,
    input  logic [1:0]               mode,
    output logic                     in_ready,
    output logic [31:0]              out_z,
    output logic [2:0]               out_lane,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [35:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          ovf;

    logic [2:0]    k;
    logic [2:0]    offs [6];
    logic [2:0]    hi_lane;
    logic          pop;
    logic          wr_en;
    logic          drop;
    logic [AW+1:0] free;
    logic [2:0]    grp;
    logic [35:0]   head;

    // Each strobed lane lands at wr_ptr plus the number of strobed lanes below it.
    always_comb begin
        k       = '0;
        hi_lane = '0;
        for (int i = 0; i < 6; i++) begin
            offs[i] = k;
            if (chain_stbs[i]) begin
                k       = k + 3'd1;
                hi_lane = 3'(i);
            end
        end
    end

    always_comb begin
        grp = 3'd6;
        case (mode)
            2'd0: grp = 3'd6;
            2'd1: grp = 3'd3;
            2'd2: grp = 3'd2;
            2'd3: grp = 3'd1;
            default: grp = 3'd6;
        endcase
    end

    assign pop   = (count != '0) & out_ready;
    assign free  = (AW+2)'(DEPTH) - (AW+2)'(count) + (AW+2)'(pop);
    assign wr_en = (k != 3'd0) && ((AW+2)'(k) <= free);
    assign drop  = (k != 3'd0) && !wr_en;

    // Occupancy only; a pop in this cycle is deliberately not credited.
    assign in_ready = ((AW+1)'(DEPTH) - count) >= (AW+1)'(grp);

    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_z     = out_valid ? head[31:0]  : 32'd0;
    assign out_lane  = out_valid ? head[34:32] : 3'd0;
    assign out_last  = out_valid ? head[35]    : 1'b0;

    assign fifo_count = count;
    assign overflow   = ovf;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 6; i++) begin
                if (chain_stbs[i]) begin
                    mem[wr_ptr + AW'(offs[i])] <= {(hi_lane == 3'(i)), 3'(i), chain_z[32*i +: 32]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(k);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (wr_en ? (AW+1)'(k) : '0) - (AW+1)'(pop);
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_result_drain.sv
// Self-checking bench for mul_result_drain against a queue-based reference model.
module tb_mul_result_drain;

    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [191:0] chain_z = '0;
    logic [5:0]   chain_stbs = '0;
    logic [1:0]   mode = '0;
    logic         in_ready;
    logic [31:0]  out_z;
    logic [2:0]   out_lane;
    logic         out_last;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [4:0]   fifo_count;
    logic         overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [35:0] q [$];
    bit          m_ovf = 1'b0;

    mul_result_drain #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .chain_z(chain_z), .chain_stbs(chain_stbs), .mode(mode),
        .in_ready(in_ready), .out_z(out_z), .out_lane(out_lane), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .fifo_count(fifo_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int grp_of(input logic [1:0] m);
        case (m)
            2'd0: return 6;
            2'd1: return 3;
            2'd2: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [5:0] mask_of(input logic [1:0] m);
        case (m)
            2'd0: return 6'b111111;
            2'd1: return 6'b101010;
            2'd2: return 6'b100100;
            default: return 6'b010000;
        endcase
    endfunction

    // Reference: one clock of the collector expressed as queue operations.
    task automatic tick();
        int  k;
        int  hi;
        int  free;
        bit  pop;
        @(posedge clk);
        pop  = (q.size() != 0) && out_ready;
        k    = $countones(chain_stbs);
        free = DEPTH - q.size() + (pop ? 1 : 0);
        hi   = -1;
        for (int i = 0; i < 6; i++) if (chain_stbs[i]) hi = i;
        if (pop) void'(q.pop_front());
        if (k > 0) begin
            if (k <= free) begin
                for (int i = 0; i < 6; i++)
                    if (chain_stbs[i]) q.push_back({(i == hi), 3'(i), chain_z[32*i +: 32]});
            end else begin
                m_ovf = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic randomize_z();
        for (int i = 0; i < 6; i++) chain_z[32*i +: 32] = $urandom;
    endtask

    task automatic test_reset();
        mode       = 2'd0;
        chain_stbs = 6'b111111;
        out_ready  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chain_stbs = '0;
        out_ready  = 1'b0;
        rst = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if ({out_last, out_lane, out_z} !== 36'd0) begin n_fail++; $display("FAIL reset_head: got %h want 0", {out_last, out_lane, out_z}); end
    endtask

    task automatic test_mode0_burst();
        mode      = 2'd0;
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) chain_z[32*n +: 32] = 32'h3F80_0000 + 32'(n);
        chain_stbs = 6'b111111;
        tick();
        chain_stbs = '0;
        n_cmp++; if (fifo_count !== 5'd6) begin n_fail++; $display("FAIL burst_peak: got %0d want 6", fifo_count); end
        for (int n = 0; n < 6; n++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL burst_valid[%0d]: got %b want 1", n, out_valid); end
            n_cmp++; if (out_lane !== 3'(n)) begin n_fail++; $display("FAIL burst_lane[%0d]: got %0d want %0d", n, out_lane, n); end
            n_cmp++; if (out_last !== (n == 5)) begin n_fail++; $display("FAIL burst_last[%0d]: got %b want %b", n, out_last, (n == 5)); end
            n_cmp++; if (out_z !== 32'h3F80_0000 + 32'(n)) begin n_fail++; $display("FAIL burst_z[%0d]: got %h want %h", n, out_z, 32'h3F80_0000 + 32'(n)); end
            tick();
        end
        n_cmp++; if (fifo_count !== 5'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL burst_drained: got count %0d valid %b want 0 0", fifo_count, out_valid); end
    endtask

    task automatic test_mode1_groups();
        mode      = 2'd1;
        out_ready = 1'b0;
        chain_stbs = 6'b101010;
        for (int g = 0; g < 4; g++) begin
            randomize_z();
            tick();
        end
        chain_stbs = '0;
        #1;
        n_cmp++; if (fifo_count !== 5'd12) begin n_fail++; $display("FAIL m1_count12: got %0d want 12", fifo_count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL m1_ready12: got %b want 1", in_ready); end
        randomize_z();
        chain_stbs = 6'b101010;
        tick();
        chain_stbs = '0;
        #1;
        n_cmp++; if (fifo_count !== 5'd15) begin n_fail++; $display("FAIL m1_count15: got %0d want 15", fifo_count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL m1_ready15: got %b want 0", in_ready); end
        n_cmp++; if ({out_last, out_lane, out_z} !== q[0]) begin n_fail++; $display("FAIL m1_head: got %h want %h", {out_last, out_lane, out_z}, q[0]); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            n_cmp++; if ({out_last, out_lane, out_z} !== q[0]) begin n_fail++; $display("FAIL ovf_pre_head[%0d]: got %h want %h", j, {out_last, out_lane, out_z}, q[0]); end
            tick();
        end
        n_cmp++; if (fifo_count !== 5'd12) begin n_fail++; $display("FAIL ovf_pre_count: got %0d want 12", fifo_count); end
        out_ready  = 1'b0;
        mode       = 2'd0;
        randomize_z();
        chain_stbs = 6'b111111;
        tick();
        chain_stbs = '0;
        n_cmp++; if (fifo_count !== 5'd12) begin n_fail++; $display("FAIL ovf_count: got %0d want 12", fifo_count); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            n_cmp++; if ({out_last, out_lane, out_z} !== q[0]) begin n_fail++; $display("FAIL ovf_post_head[%0d]: got %h want %h", j, {out_last, out_lane, out_z}, q[0]); end
            tick();
        end
        n_cmp++; if (overflow !== 1'b1 || fifo_count !== 5'd8) begin n_fail++; $display("FAIL ovf_sticky: got ovf %b count %0d want 1 8", overflow, fifo_count); end
    endtask

    task automatic test_same_cycle_pop();
        logic [31:0] marker;
        marker = 32'hC0DE_0004;
        test_reset();
        out_ready  = 1'b0;
        mode       = 2'd1;
        chain_stbs = 6'b101010;
        for (int g = 0; g < 5; g++) begin randomize_z(); tick(); end
        mode       = 2'd3;
        chain_stbs = 6'b010000;
        randomize_z();
        tick();
        n_cmp++; if (fifo_count !== 5'd16 || out_valid !== 1'b1) begin n_fail++; $display("FAIL scp_full: got count %0d valid %b want 16 1", fifo_count, out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL scp_in_ready: got %b want 0", in_ready); end
        chain_z[32*4 +: 32] = marker;
        out_ready = 1'b1;
        tick();
        chain_stbs = '0;
        n_cmp++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL scp_count: got %0d want 16", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL scp_overflow: got %b want 0", overflow); end
        // A two-lane group against a full FIFO is refused even with a pop.
        mode       = 2'd2;
        chain_stbs = 6'b100100;
        randomize_z();
        tick();
        chain_stbs = '0;
        n_cmp++; if (fifo_count !== 5'd15 || overflow !== 1'b1) begin n_fail++; $display("FAIL scp_k2_drop: got count %0d ovf %b want 15 1", fifo_count, overflow); end
        for (int j = 0; j < 15; j++) begin
            n_cmp++; if ({out_last, out_lane, out_z} !== q[0]) begin n_fail++; $display("FAIL scp_head[%0d]: got %h want %h", j, {out_last, out_lane, out_z}, q[0]); end
            if (j == 14) begin
                n_cmp++; if ({out_last, out_lane, out_z} !== {1'b1, 3'd4, marker}) begin n_fail++; $display("FAIL scp_marker: got %h want %h", {out_last, out_lane, out_z}, {1'b1, 3'd4, marker}); end
            end
            tick();
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL scp_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure_wrap();
        int          groups;
        int          cycles;
        bit          prev_stall;
        logic [35:0] prev_head;
        test_reset();
        groups     = 0;
        cycles     = 0;
        prev_stall = 1'b0;
        prev_head  = '0;
        while (groups < 40 && cycles < 3000) begin
            if (prev_stall) begin
                n_cmp++; if ({out_last, out_lane, out_z} !== prev_head) begin n_fail++; $display("FAIL bp_stable[%0d]: got %h want %h", cycles, {out_last, out_lane, out_z}, prev_head); end
            end
            out_ready  = ($urandom_range(0, 2) != 0);
            chain_stbs = '0;
            if ($urandom_range(0, 1) == 1) begin
                mode = 2'($urandom_range(0, 3));
                #1;
                n_cmp++; if (in_ready !== ((DEPTH - q.size()) >= grp_of(mode))) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want %b", cycles, in_ready, ((DEPTH - q.size()) >= grp_of(mode))); end
                if (in_ready) begin
                    randomize_z();
                    chain_stbs = mask_of(mode);
                    groups++;
                end
            end
            #1;
            n_cmp++; if (fifo_count !== 5'(q.size()) || out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL bp_count[%0d]: got %0d/%b want %0d", cycles, fifo_count, out_valid, q.size()); end
            if (q.size() != 0) begin
                n_cmp++; if ({out_last, out_lane, out_z} !== q[0]) begin n_fail++; $display("FAIL bp_head[%0d]: got %h want %h", cycles, {out_last, out_lane, out_z}, q[0]); end
            end
            prev_stall = out_valid && !out_ready;
            prev_head  = {out_last, out_lane, out_z};
            tick();
            cycles++;
        end
        n_cmp++; if (groups != 40) begin n_fail++; $display("FAIL bp_budget: got %0d groups want 40", groups); end
        chain_stbs = '0;
        out_ready  = 1'b1;
        cycles     = 0;
        while (q.size() != 0 && cycles < 100) begin
            n_cmp++; if ({out_last, out_lane, out_z} !== q[0]) begin n_fail++; $display("FAIL bp_drain[%0d]: got %h want %h", cycles, {out_last, out_lane, out_z}, q[0]); end
            tick();
            cycles++;
        end
        n_cmp++; if (out_valid !== 1'b0 || fifo_count !== 5'd0) begin n_fail++; $display("FAIL bp_end_empty: got valid %b count %0d want 0 0", out_valid, fifo_count); end
        n_cmp++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL bp_overflow: got %b want %b", overflow, m_ovf); end
    endtask

    initial begin
        test_reset();
        test_mode0_burst();
        test_mode1_groups();
        test_overflow();
        test_same_cycle_pop();
        test_backpressure_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_result_drain.md
# mul_result_drain

Result-side collector for the six-lane bf16 multiplier chain. It captures every strobed lane result from the chain's packed 6×32 output bus and buffers it in a FIFO, up to six entries in one cycle. It emits the results one per cycle on a valid/ready stream, tagged with lane index and an end-of-group flag. An `in_ready` back-pressure signal tells the operand issuer whether a further `mul_stb` is safe, because the chain itself has no stall.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 8.
- `clk` input 1: single clock; all state is updated on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `chain_z` input 192: packed chain results; lane n is bits [32n+31:32n].
- `chain_stbs` input 6: mode-masked final strobes; bit n qualifies lane n.
- `mode` input 2: chain mode. 0 = two-input, 1 = three-input, 2 = four-input, 3 = six-input.
- `in_ready` output 1: the FIFO has room for one full result group of the current mode.
- `out_z` output 32: head result.
- `out_lane` output 3: lane index (0–5) of the head result.
- `out_last` output 1: the head is the highest-indexed lane of its capture group.
- `out_valid` output 1: head entry present.
- `out_ready` input 1: the consumer accepts the head.
- `fifo_count` output $clog2(DEPTH)+1: occupied entries.
- `overflow` output 1: sticky; set when a group is dropped.

## Operation
- **Entry format:** each entry is 36 bits, {last, lane[2:0], z[31:0]}.
- **Group size G per mode:** mode 0 gives 6 (lanes 0–5); mode 1 gives 3 (lanes 1, 3, 5); mode 2 gives 2 (lanes 2, 5); mode 3 gives 1 (lane 4).
- **Capture:**
  - k = popcount(`chain_stbs`).
  - When k > 0, the strobed lanes are written in ascending lane order to consecutive slots starting at the write pointer.
  - Only the highest strobed lane gets last = 1.
  - The strobe pattern is taken as given; it is not re-masked by `mode`.
- **Pop:** pop = `out_valid` & `out_ready`. The read pointer advances by one on a pop.
- **Free space:** free = DEPTH − `fifo_count` + pop. A pop in the same cycle frees its slot for that cycle's write.
- **Write decision:**
  - If k ≤ free, all k lanes are written.
  - Otherwise the whole group is dropped (no partial write) and `overflow` is set.
- **Count update:** `fifo_count` next = `fifo_count` + (written ? k : 0) − pop.
- **Pointers:** both pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- **`in_ready`:** combinational, = (DEPTH − `fifo_count`) ≥ G(`mode`). It does not count a same-cycle pop. A `mode` change takes effect in the same cycle.
- **Output path:** first-word-fall-through.
  - `out_valid` = (`fifo_count` ≠ 0).
  - `out_z`, `out_lane` and `out_last` are driven from the head slot.
  - These head fields must remain stable while `out_valid` = 1 and `out_ready` = 0.
- **`overflow`:** cleared only by reset.

## Timing
- **Reset values:** pointers 0, `fifo_count` 0, `out_valid` 0, `out_z` 0, `out_lane` 0, `out_last` 0, `overflow` 0. `in_ready` is 1 because DEPTH ≥ 6.
- **Latency:** a strobe in cycle N gives `out_valid` = 1 in cycle N+1 when the FIFO was empty.
- **Throughput:** one result per cycle out; up to 6 in.
- **Full FIFO:** `out_valid` stays high. A group with k ≥ 2 is dropped even if a pop occurs that cycle; k = 1 with a pop is accepted.
- **Empty FIFO:** `out_ready` is ignored and no pop occurs.
- **Simultaneous capture and pop:** both happen in the same cycle with the net count update above.
- **Reset mid-operation:** asserting `rst` clears all state immediately (asynchronously), including any buffered entries. Strobes during reset are discarded.
- **Issuer rule:** the issuer must sample `in_ready` at issue time and budget for the 3-cycle chain latency. `in_ready` guarantees room only against the current occupancy.

## Test plan
- **Reset:** hold `rst` = 0 for 3 cycles, then release. Require `out_valid` = 0, `fifo_count` = 0, `overflow` = 0, `in_ready` = 1.
- **Mode 0 burst:** `mode` = 0, `chain_stbs` = 6'b111111 for one cycle, `chain_z` lanes = 0x3F80_0000 + n, `out_ready` = 1. Require 6 consecutive outputs in the following cycles, `out_lane` 0..5 in order, `out_last` only on lane 5, `fifo_count` peaking at 6.
- **Mode 1 groups:** `mode` = 1, `chain_stbs` = 6'b101010 in 4 consecutive cycles with `out_ready` = 0. Require `fifo_count` = 12 and `in_ready` = 1. Send one more group: require `fifo_count` = 15 and `in_ready` = 0.
- **Overflow:** `mode` = 0, DEPTH = 16, `fifo_count` = 12, `out_ready` = 0, push 6'b111111. Require the group dropped, `fifo_count` still 12, `overflow` = 1 and remaining 1 after further pops.
- **Same-cycle pop:** FIFO full (16), `mode` = 3, `chain_stbs` = 6'b010000, `out_ready` = 1. Require the entry accepted, `fifo_count` = 16, `overflow` = 0, and the lane-4 entry emerging 16 pops later.
- **Backpressure and wrap:** randomly toggle `out_ready` over 40 groups in mixed modes with `in_ready` respected. Require the output sequence to equal the scoreboard and the head to be stable while stalled.
